reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the register-file write port.
REQ-002 Parameter LOCK_MAX, default 4, maximum consecutive grants to one locked requester.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 clr  input  1  reset; synchronous and active-high.
REQ-005 req  input  N_REQ  per-requester write request.
REQ-006 req_addr  input  5*N_REQ  flat target register addresses; requester i occupies bits [5i+4:5i].
REQ-007 req_data  input  32*N_REQ  flat write data; requester i occupies bits [32i+31:32i].
REQ-008 req_lock  input  N_REQ  burst-lock hint; ignored when REG_ARB_LOCK_EN is undefined.
REQ-009 gnt  output  N_REQ  one-hot grant, combinational, in the acceptance cycle.
REQ-010 wr_en  output  1  registered write enable to the 32x32 register file.
REQ-011 wr_addr  output  5  registered write address.
REQ-012 wr_data  output  32  registered write data.
REQ-013 busy  output  1  registered; high while state is not IDLE.

Function
REQ-014 At most one gnt bit shall be high in any cycle; gnt shall be all-zero when req is all-zero or clr is high.
REQ-015 Winner selection shall use round-robin priority starting at pointer ptr: the first requester i with req[i]=1 in the order ptr, ptr+1, ..., wrapping modulo N_REQ.
REQ-016 A request is accepted in the cycle its gnt bit is high; requesters shall hold req, address and data stable until then.
REQ-017 After accepting requester w, ptr shall become (w+1) mod N_REQ; ptr shall be unchanged in cycles with no grant.
REQ-018 wr_en, wr_addr and wr_data shall reflect the accepted request exactly one cycle after gnt (latency 1).
REQ-019 Accepted writes to address 0 shall be granted but dropped: wr_en=0 the next cycle, wr_addr/wr_data hold their previous values.
REQ-020 In cycles after no acceptance, wr_en shall be 0 and wr_addr/wr_data shall hold their previous values.
REQ-021 Back-to-back acceptance every cycle shall be supported with no bubble.
REQ-022 State machine: IDLE (no grant last cycle), ACTIVE (grant last cycle, unlocked) and LOCKED (lock held). Any state moves to ACTIVE or LOCKED on a grant and to IDLE on a cycle with no grant.

Reset
REQ-023 While clr is high at a clock edge, the block shall set gnt=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, ptr=0, the lock count to 0 and the state to IDLE.
REQ-024 A request granted in the cycle before clr shall be discarded, and wr_en shall be 0 in the cycle after the reset edge.

Configuration
REQ-025 With macro REG_ARB_LOCK_EN defined, the block shall behave as follows. If the winner had req_lock=1, the state becomes LOCKED. While LOCKED and that requester still asserts req, it shall win regardless of ptr. ptr shall not advance until the lock is released. The lock is released when req_lock drops, req drops, or LOCK_MAX consecutive grants are reached. On release, ptr shall become owner+1.
REQ-026 Without REG_ARB_LOCK_EN, the block shall ignore req_lock, shall never enter LOCKED, and shall contain no lock counter logic.

Structure
REQ-027 N_REQ, LOCK_MAX, the address width (5), the data width (32) and the state encoding (IDLE=0, ACTIVE=1, LOCKED=2) shall reside in the shared package reg_arb_pkg.
REQ-028 Rotating-priority selection shall be a sub-module rr_pick (inputs req and ptr, output one-hot gnt), purely combinational; all state shall stay in reg_write_arbiter.

Verification
REQ-029 Reset check: after clr, with req=4'b0000 -> gnt=0, wr_en=0, wr_addr=0, wr_data=0 and busy=0.
REQ-030 Round-robin check: req=4'b1111 held for 4 cycles from reset -> gnt sequence 0001, 0010, 0100, 1000; wr_en=1 on cycles 2-5 with the matching addresses and data.
REQ-031 Register-0 drop check: requester 2 writes addr 0, data 0xDEADBEEF -> gnt=0100, then wr_en=0 the next cycle and the previous wr_addr/wr_data are held.
REQ-032 Reset mid-operation check: gnt=0001 at cycle N and clr=1 at cycle N -> wr_en=0 at N+1, and the first grant after reset goes to requester 0.
REQ-033 Lock check (REG_ARB_LOCK_EN): req=4'b0011 with req_lock[0]=1 held -> gnt=0001 for 4 cycles, then 0010, then 0001.
REQ-034 Lock-disabled check (no macro): the same stimulus as REQ-033 -> gnt alternates 0001, 0010, 0001, ...

Source files
------------

// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared sizes and state encoding for the register-file write arbiter
package reg_arb_pkg;

  localparam int N_REQ    = 4;   // requesters sharing the write port
  localparam int LOCK_MAX = 4;   // longest run of grants to one locked requester
  localparam int ADDR_W   = 5;   // 32-entry register file
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  // Width of a requester index; never below one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority one-hot picker
//
// Ports:
//   req  in   N   request vector
//   ptr  in   PW  index with highest priority this cycle (must be < N)
//   gnt  out  N   one-hot winner, all-zero when req is all-zero
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Walk ptr, ptr+1, ... modulo N; the first asserted request wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter for the shared register-file write port
//
// Optional burst lock: define REG_ARB_LOCK_EN to honour req_lock.
//
// Ports:
//   clk       in   1          rising-edge clock
//   clr       in   1          synchronous active-high reset
//   req       in   N_REQ      per-requester write request
//   req_addr  in   5*N_REQ    flat addresses, requester i at [5i+4:5i]
//   req_data  in   32*N_REQ   flat data, requester i at [32i+31:32i]
//   req_lock  in   N_REQ      burst-lock hint (lock build only)
//   gnt       out  N_REQ      one-hot combinational grant = acceptance
//   wr_en     out  1          registered register-file write enable
//   wr_addr   out  5          registered write address
//   wr_data   out  32         registered write data
//   busy      out  1          high while state is not IDLE
module reg_write_arbiter #(
  parameter int N_REQ    = reg_arb_pkg::N_REQ,
  parameter int LOCK_MAX = reg_arb_pkg::LOCK_MAX
) (
  input  logic                                   clk,
  input  logic                                   clr,
  input  logic [N_REQ-1:0]                       req,
  input  logic [reg_arb_pkg::ADDR_W*N_REQ-1:0]   req_addr,
  input  logic [reg_arb_pkg::DATA_W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]                       req_lock,
  output logic [N_REQ-1:0]                       gnt,
  output logic                                   wr_en,
  output logic [reg_arb_pkg::ADDR_W-1:0]         wr_addr,
  output logic [reg_arb_pkg::DATA_W-1:0]         wr_data,
  output logic                                   busy
);

  import reg_arb_pkg::*;

  localparam int PW = ptr_width(N_REQ);

  arb_state_t        state, state_nxt;
  logic [PW-1:0]     ptr, ptr_nxt, pick_ptr, win_idx;
  logic [N_REQ-1:0]  rr_gnt;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(N_REQ-1)) ? '0 : p + 1'b1;
  endfunction

`ifdef REG_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX+1);
  logic [CW-1:0] lock_cnt, lock_cnt_nxt;
  logic [PW-1:0] owner, owner_nxt;
  logic          lock_hold;

  // Owner keeps the port while it still requests with lock and has budget left.
  assign lock_hold = (state == ST_LOCKED) && req[owner] && req_lock[owner] &&
                     (lock_cnt < CW'(LOCK_MAX));

  // ptr is frozen during a lock; once released, arbitration resumes after the owner.
  always_comb begin
    pick_ptr = ptr;
    if (state == ST_LOCKED) begin
      pick_ptr = inc_ptr(owner);
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign pick_ptr    = ptr;
`endif

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .gnt (rr_gnt)
  );

  always_comb begin
    gnt = '0;
    if (!clr) begin
`ifdef REG_ARB_LOCK_EN
      if (lock_hold) begin
        gnt[owner] = 1'b1;
      end else begin
        gnt = rr_gnt;
      end
`else
      gnt = rr_gnt;
`endif
    end
  end

  // Winner index and its address/data from the one-hot grant.
  always_comb begin
    win_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win_idx  = PW'(i);
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accept = |gnt;

  always_comb begin
    state_nxt = ST_IDLE;
    ptr_nxt   = ptr;
`ifdef REG_ARB_LOCK_EN
    lock_cnt_nxt = '0;
    owner_nxt    = owner;
    if (accept) begin
      if (req_lock[win_idx]) begin
        state_nxt    = ST_LOCKED;
        owner_nxt    = win_idx;
        lock_cnt_nxt = lock_hold ? lock_cnt + 1'b1 : CW'(1);
      end else begin
        state_nxt = ST_ACTIVE;
        ptr_nxt   = inc_ptr(win_idx);
      end
    end else if (state == ST_LOCKED) begin
      ptr_nxt = inc_ptr(owner);
    end
`else
    if (accept) begin
      state_nxt = ST_ACTIVE;
      ptr_nxt   = inc_ptr(win_idx);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
`ifdef REG_ARB_LOCK_EN
      lock_cnt <= '0;
      owner    <= '0;
`endif
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      // Writes to register 0 are accepted but never reach the register file.
      wr_en <= accept && (sel_addr != '0);
      if (accept && (sel_addr != '0)) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
`ifdef REG_ARB_LOCK_EN
      lock_cnt <= lock_cnt_nxt;
      owner    <= owner_nxt;
`endif
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

  logic         clk;
  logic         clr;
  logic [3:0]   req;
  logic [19:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   req_lock;
  logic [3:0]   gnt;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         busy;

  logic [4:0]  a [4];
  logic [31:0] d [4];
  logic [3:0]  exp_seq [6];

  int n_checks = 0;
  int n_errors = 0;

  assign req_addr = {a[3], a[2], a[1], a[0]};
  assign req_data = {d[3], d[2], d[1], d[0]};

  reg_write_arbiter dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_lock (req_lock),
    .gnt      (gnt),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr      = 1'b1;
    req      = 4'b1111;
    req_lock = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      a[i] = 5'(10 + i);
      d[i] = 32'hA000_0000 + 32'(i);
    end
    #1;
    check("gnt_during_clr", 32'(gnt), 32'h0);
    tick();
    tick();

    // Reset state
    clr = 1'b0;
    req = 4'b0000;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", wr_data, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Round robin, back-to-back
    req = 4'b1111;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(4'b0001 << k));
      tick();
      check($sformatf("rr_wr_en%0d", k), 32'(wr_en), 32'h1);
      check($sformatf("rr_wr_addr%0d", k), 32'(wr_addr), 32'(10 + k));
      check($sformatf("rr_wr_data%0d", k), wr_data, 32'hA000_0000 + 32'(k));
      check($sformatf("rr_busy%0d", k), 32'(busy), 32'h1);
    end
    req = 4'b0000;
    #1;
    check("idle_gnt", 32'(gnt), 32'h0);
    tick();
    check("idle_wr_en", 32'(wr_en), 32'h0);
    check("idle_wr_addr", 32'(wr_addr), 32'd13);
    check("idle_busy", 32'(busy), 32'h0);

    // Register 0 write is granted but dropped
    a[2] = 5'd0;
    d[2] = 32'hDEAD_BEEF;
    req  = 4'b0100;
    #1;
    check("r0_gnt", 32'(gnt), 32'h4);
    tick();
    check("r0_wr_en", 32'(wr_en), 32'h0);
    check("r0_wr_addr", 32'(wr_addr), 32'd13);
    check("r0_wr_data", wr_data, 32'hA000_0003);
    check("r0_busy", 32'(busy), 32'h1);
    a[2] = 5'd12;
    d[2] = 32'hA000_0002;

    // Pointer now 3: wrap to requester 1, then from 2 pick 3
    req = 4'b0010;
    #1;
    check("wrap_gnt", 32'(gnt), 32'h2);
    tick();
    check("wrap_wr_addr", 32'(wr_addr), 32'd11);
    req = 4'b1010;
    #1;
    check("ptr2_gnt", 32'(gnt), 32'h8);
    tick();
    check("ptr2_wr_data", wr_data, 32'hA000_0003);

    // Reset mid-operation
    req = 4'b0010;
    #1;
    check("pre_gnt", 32'(gnt), 32'h2);
    tick();
    req = 4'b0100;
    #1;
    check("midN_gnt", 32'(gnt), 32'h4);
    clr = 1'b1;
    #1;
    check("midN_gnt_clr", 32'(gnt), 32'h0);
    tick();
    check("mid_wr_en", 32'(wr_en), 32'h0);
    check("mid_wr_addr", 32'(wr_addr), 32'h0);
    check("mid_wr_data", wr_data, 32'h0);
    check("mid_busy", 32'(busy), 32'h0);
    clr = 1'b0;
    req = 4'b1111;
    #1;
    check("post_rst_gnt", 32'(gnt), 32'h1);
    tick();
    check("post_rst_wr_addr", 32'(wr_addr), 32'd10);
    req = 4'b0000;
    tick();

    // Lock behaviour
    clr = 1'b1;
    tick();
    clr = 1'b0;
`ifdef REG_ARB_LOCK_EN
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0001;
    exp_seq[3] = 4'b0001; exp_seq[4] = 4'b0010; exp_seq[5] = 4'b0001;
`else
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0001;
    exp_seq[3] = 4'b0010; exp_seq[4] = 4'b0001; exp_seq[5] = 4'b0010;
`endif
    req      = 4'b0011;
    req_lock = 4'b0001;
    #1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("lock_gnt%0d", k), 32'(gnt), 32'(exp_seq[k]));
      tick();
    end
    req      = 4'b0000;
    req_lock = 4'b0000;
    tick();
    check("end_busy", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
